// File: rtl/delay_ring.sv
// delay_ring: runtime-programmable delay line built on a circular buffer.
//
// Each enabled edge (rst=0, ce=1) writes d into the buffer at the write
// pointer and loads q with the sample written De enabled edges earlier,
// where De = max(dly, 1). A saturating history counter gates q_valid so that
// warm-up slots and pre-reset contents never reach q as valid data.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset (priority over ce)
//   ce       clock enable, one sample per enabled edge
//   dly      requested delay in enabled edges (0 behaves as 1)
//   d        input sample
//   q        delayed sample, registered; 0 while not valid
//   q_valid  q holds a genuine delayed sample
module delay_ring #(
  parameter int N  = 16,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic [AW-1:0] dly,
  input  logic [N-1:0]  d,
  output logic [N-1:0]  q,
  output logic          q_valid
);

  localparam int DEPTH = 1 << AW;

  logic [N-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] de;
  logic [AW-1:0] rd_addr;
  logic          hit;
  logic [N-1:0]  q_d;
  logic          q_valid_d;

  always_comb begin
    de        = (dly == '0) ? AW'(1) : dly;
    // De >= 1 means the read slot is never the slot being written this edge,
    // so the RAM read always sees committed data and no bypass mux is needed.
    // With De = 2^AW-1 this lands on wr_ptr+1, the oldest retained entry.
    rd_addr   = wr_ptr_q - de;
    // cnt_q holds k-1 (saturated) at enabled edge k, so k > De <=> cnt_q >= De.
    // Saturation at 2^AW-1 is enough because De never exceeds that value.
    hit       = (cnt_q >= de);
    wr_ptr_d  = wr_ptr_q + AW'(1);
    cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + AW'(1);
    q_d       = hit ? mem_q[rd_addr] : '0;
    q_valid_d = hit;
  end

  // Storage has no reset so it can map onto distributed or block RAM; the
  // history counter makes its post-reset contents irrelevant.
  always_ff @(posedge clk) begin
    if (!rst && ce) begin
      mem_q[wr_ptr_q] <= d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      q        <= '0;
      q_valid  <= 1'b0;
    end else if (ce) begin
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      q        <= q_d;
      q_valid  <= q_valid_d;
    end
  end

endmodule

// File: tb/tb_delay_ring.sv
module tb_delay_ring;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [4:0]  dly;
  logic [15:0] d;
  logic [15:0] q;
  logic        q_valid;

  int checks = 0;
  int errors = 0;

  // Reference model: list of every sample since reset, indexed by k-1.
  logic [15:0] hist[$];
  int          k;
  logic [15:0] exp_q;
  logic        exp_v;

  delay_ring #(.N(16), .AW(5)) dut (
    .clk(clk), .rst(rst), .ce(ce), .dly(dly), .d(d), .q(q), .q_valid(q_valid)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic step(input bit r, input bit c, input logic [4:0] dl, input logic [15:0] dv);
    int de;
    rst = r; ce = c; dly = dl; d = dv;
    @(posedge clk);
    if (r) begin
      hist.delete();
      k = 0;
      exp_q = '0;
      exp_v = 1'b0;
    end else if (c) begin
      hist.push_back(dv);
      k++;
      de = (dl == 0) ? 1 : int'(dl);
      if (k > de) begin
        exp_q = hist[k - de - 1];
        exp_v = 1'b1;
      end else begin
        exp_q = '0;
        exp_v = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 5'd3, 16'hbeef);
    checks++;
    if (q !== 16'd0 || q_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset: q=%0d valid=%0d, expected q=0 valid=0", q, q_valid);
    end
  endtask

  task automatic test_dly1();
    step(1, 1, 5'd1, 16'd0);
    for (int i = 1; i <= 10; i++) begin
      step(0, 1, 5'd1, 16'(i));
      checks++;
      if (q !== exp_q || q_valid !== exp_v || (i >= 2 && q !== 16'(i - 1))) begin
        errors++;
        $display("FAIL dly1 edge %0d: q=%0d valid=%0d, expected q=%0d valid=%0d", i, q, q_valid, exp_q, exp_v);
      end
    end
  endtask

  task automatic test_dly5();
    step(1, 1, 5'd5, 16'd0);
    for (int i = 1; i <= 10; i++) begin
      step(0, 1, 5'd5, 16'(i));
      checks++;
      if (q !== exp_q || q_valid !== exp_v || q_valid !== (i >= 6) || (i >= 6 && q !== 16'(i - 5))) begin
        errors++;
        $display("FAIL dly5 edge %0d: q=%0d valid=%0d, expected q=%0d valid=%0d", i, q, q_valid, exp_q, exp_v);
      end
    end
  endtask

  task automatic test_ce_gaps();
    bit          pat[8] = '{1, 0, 0, 1, 1, 0, 1, 1};
    logic [15:0] prev_q;
    logic        prev_v;
    int          en;
    step(1, 1, 5'd3, 16'd0);
    en = 0;
    for (int i = 0; i < 8; i++) begin
      prev_q = q;
      prev_v = q_valid;
      if (pat[i]) en++;
      step(0, pat[i], 5'd3, pat[i] ? 16'(en) : 16'hdead);
      checks++;
      if (q !== exp_q || q_valid !== exp_v ||
          (!pat[i] && (q !== prev_q || q_valid !== prev_v)) ||
          (pat[i] && en == 4 && q !== 16'd1) || (pat[i] && en == 5 && q !== 16'd2)) begin
        errors++;
        $display("FAIL ce_gaps cycle %0d: q=%0d valid=%0d, expected q=%0d valid=%0d", i, q, q_valid, exp_q, exp_v);
      end
    end
  endtask

  task automatic test_dly_decrease();
    step(1, 1, 5'd8, 16'd0);
    for (int i = 1; i <= 40; i++) step(0, 1, 5'd8, 16'(i));
    step(0, 1, 5'd3, 16'd41);
    checks++;
    if (q !== 16'd38 || q_valid !== 1'b1 || q !== exp_q) begin
      errors++;
      $display("FAIL dly_decrease: q=%0d valid=%0d, expected q=38 valid=1", q, q_valid);
    end
  endtask

  task automatic test_dly_increase();
    step(1, 1, 5'd3, 16'd0);
    for (int i = 1; i <= 4; i++) step(0, 1, 5'd3, 16'(i));
    for (int i = 5; i <= 9; i++) begin
      step(0, 1, 5'd8, 16'(i));
      checks++;
      if (q !== exp_q || q_valid !== exp_v || q_valid !== (i == 9) || (i < 9 && q !== 16'd0) || (i == 9 && q !== 16'd1)) begin
        errors++;
        $display("FAIL dly_increase edge %0d: q=%0d valid=%0d, expected q=%0d valid=%0d", i, q, q_valid, exp_q, exp_v);
      end
    end
  endtask

  task automatic test_wrap();
    step(1, 1, 5'd31, 16'd0);
    for (int i = 1; i <= 100; i++) begin
      step(0, 1, 5'd31, 16'(i));
      checks++;
      if (q !== exp_q || q_valid !== exp_v || (i == 32 && q !== 16'd1) || (i == 100 && q !== 16'd69)) begin
        errors++;
        $display("FAIL wrap edge %0d: q=%0d valid=%0d, expected q=%0d valid=%0d", i, q, q_valid, exp_q, exp_v);
      end
    end
  endtask

  task automatic test_dly0();
    step(1, 1, 5'd0, 16'd0);
    for (int i = 1; i <= 12; i++) begin
      step(0, 1, 5'd0, 16'(i * 7));
      checks++;
      if (q !== exp_q || q_valid !== exp_v || (i >= 2 && q !== 16'((i - 1) * 7))) begin
        errors++;
        $display("FAIL dly0 edge %0d: q=%0d valid=%0d, expected q=%0d valid=%0d", i, q, q_valid, exp_q, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1, 1, 5'd4, 16'd0);
    for (int i = 1; i <= 20; i++) step(0, 1, 5'd4, 16'(i));
    step(1, 1, 5'd4, 16'd500);
    checks++;
    if (q !== 16'd0 || q_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: q=%0d valid=%0d, expected q=0 valid=0", q, q_valid);
    end
    for (int i = 1; i <= 6; i++) begin
      step(0, 1, 5'd4, 16'(1000 + i));
      checks++;
      if (q !== exp_q || q_valid !== exp_v || q_valid !== (i >= 5) || (i == 5 && q !== 16'd1001)) begin
        errors++;
        $display("FAIL reset_mid edge %0d: q=%0d valid=%0d, expected q=%0d valid=%0d", i, q, q_valid, exp_q, exp_v);
      end
    end
  endtask

  task automatic test_random();
    step(1, 1, 5'd1, 16'd0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           5'($urandom_range(0, 31)), 16'($urandom));
      checks++;
      if (q !== exp_q || q_valid !== exp_v) begin
        errors++;
        $display("FAIL random cycle %0d: q=%0d valid=%0d, expected q=%0d valid=%0d", i, q, q_valid, exp_q, exp_v);
      end
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; dly = '0; d = '0;
    k = 0; exp_q = '0; exp_v = 1'b0;
    test_reset();
    test_dly1();
    test_dly5();
    test_ce_gaps();
    test_dly_decrease();
    test_dly_increase();
    test_wrap();
    test_dly0();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
